// File: rtl/keypad_press_gen.sv
// Keypad press generator: buffers 4-bit key codes and replays each one as a
// timed, optionally bouncing, one-hot press on a 12-line keypad bus.
module keypad_press_gen #(
  parameter int HOLD_CYC   = 8,
  parameter int GAP_CYC    = 4,
  parameter int BOUNCE_CYC = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  code_in,
  input  logic        code_valid,
  output logic        code_ready,
  output logic [11:0] keypad_out,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int AW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNTW   = AW + 1;
  localparam int HG_MAX = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
  localparam int MAXC   = (HG_MAX > BOUNCE_CYC) ? HG_MAX : BOUNCE_CYC;
  localparam int CW     = (MAXC > 1) ? $clog2(MAXC) : 1;

  // Bounce cycle k is high on even k; k counts up while the counter counts down.
  localparam bit HIGH_PAR = ((BOUNCE_CYC + 1) % 2) == 1;

  typedef enum logic [1:0] {IDLE, BOUNCE, HOLD, GAP} state_t;

  localparam state_t         START_ST  = (BOUNCE_CYC > 0) ? BOUNCE : HOLD;
  localparam logic [CW-1:0]  START_CNT = CW'((BOUNCE_CYC > 0) ? BOUNCE_CYC - 1 : HOLD_CYC - 1);
  localparam logic [CW-1:0]  HOLD_LOAD = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0]  GAP_LOAD  = CW'(GAP_CYC - 1);

  logic [3:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CNTW-1:0] count;
  logic            accept, push, pop, fifo_empty;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      code_q, code_d;
  logic [11:0]     onehot, kp_d;
  logic            busy_d, done_d;

  assign code_ready = !rst && (count != CNTW'(FIFO_DEPTH));
  assign accept     = code_valid && code_ready;
  assign push       = accept && (code_in < 4'd12);
  assign fifo_empty = (count == '0);
  assign onehot     = 12'd1 << code_q;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= code_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CNTW'(1);
        2'b01:   count <= count - CNTW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      code_q     <= '0;
      keypad_out <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      code_q     <= code_d;
      keypad_out <= kp_d;
      busy       <= busy_d;
      done       <= done_d;
      err        <= accept && (code_in >= 4'd12);
    end
  end

  // Outputs are decoded from the current state and registered, so the bus
  // trails the state register by one cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    pop     = 1'b0;
    kp_d    = '0;
    busy_d  = (state_q != IDLE);
    done_d  = 1'b0;
    if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          code_d  = mem[rd_ptr];
          state_d = START_ST;
          cnt_d   = START_CNT;
        end
      end
      BOUNCE: begin
        if (cnt_q[0] == HIGH_PAR) kp_d = onehot;
        if (cnt_q == '0) begin
          state_d = HOLD;
          cnt_d   = HOLD_LOAD;
        end
      end
      HOLD: begin
        kp_d = onehot;
        if (cnt_q == '0) begin
          state_d = GAP;
          cnt_d   = GAP_LOAD;
        end
      end
      GAP: begin
        if (cnt_q == '0) begin
          done_d = 1'b1;
          if (!fifo_empty) begin
            pop     = 1'b1;
            code_d  = mem[rd_ptr];
            state_d = START_ST;
            cnt_d   = START_CNT;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_keypad_press_gen.sv
// Self-checking bench for keypad_press_gen: directed scenarios plus a random
// run against a press-schedule reference model.
module tb_keypad_press_gen;
  localparam int B = 2, H = 8, G = 4, P = B + H + G;

  logic clk = 1'b0;
  logic rst, code_valid;
  logic [3:0] code_in;
  logic code_ready, busy, done, err;
  logic [11:0] keypad_out;
  logic code_ready_b, busy_b, done_b, err_b;
  logic [11:0] keypad_out_b;

  keypad_press_gen #(.HOLD_CYC(H), .GAP_CYC(G), .BOUNCE_CYC(B), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .code_in(code_in), .code_valid(code_valid),
    .code_ready(code_ready), .keypad_out(keypad_out), .busy(busy), .done(done), .err(err));

  keypad_press_gen #(.HOLD_CYC(8), .GAP_CYC(4), .BOUNCE_CYC(0), .FIFO_DEPTH(4)) dut_nb (
    .clk(clk), .rst(rst), .code_in(code_in), .code_valid(code_valid),
    .code_ready(code_ready_b), .keypad_out(keypad_out_b), .busy(busy_b), .done(done_b), .err(err_b));

  always #5 clk = ~clk;

  typedef struct {int start; int code;} press_t;
  press_t presses[$];
  int pop_q[$];
  int err_q[$];
  int n_vec = 0, n_bad = 0, cyc = 0, last_end = 0;
  logic ready_seen, exp_ready;

  // Each accepted code becomes a press starting at max(end of previous press, accept edge + 2).
  function automatic void model_out(input int c, output logic [11:0] kp, output logic bz,
                                    output logic dn, output logic er);
    kp = '0; bz = 1'b0; dn = 1'b0; er = 1'b0;
    foreach (presses[i]) begin
      int o;
      o = c - presses[i].start;
      if (o >= 0 && o < P) begin
        bz = 1'b1;
        dn = (o == P - 1);
        if (o < B) begin
          if (o % 2 == 0) kp = 12'd1 << presses[i].code;
        end else if (o < B + H) begin
          kp = 12'd1 << presses[i].code;
        end
      end
    end
    foreach (err_q[i]) if (err_q[i] == c) er = 1'b1;
  endfunction

  task automatic step(input logic r, input logic v, input logic [3:0] c);
    rst = r; code_valid = v; code_in = c;
    #1;
    while (pop_q.size() > 0 && pop_q[0] <= cyc) void'(pop_q.pop_front());
    ready_seen = code_ready;
    exp_ready  = !r && (pop_q.size() < 4);
    @(posedge clk);
    cyc++;
    if (r) begin
      presses.delete(); pop_q.delete(); err_q.delete(); last_end = 0;
    end else if (v && ready_seen) begin
      if (c < 4'd12) begin
        int s;
        s = (last_end > cyc + 2) ? last_end : cyc + 2;
        presses.push_back('{s, int'(c)});
        last_end = s + P;
        pop_q.push_back(s - 1);
      end else begin
        err_q.push_back(cyc);
      end
    end
    #1;
  endtask

  task automatic test_reset();
    step(1'b1, 1'b0, 4'd0);
    step(1'b1, 1'b1, 4'd3);
    n_vec++; if (ready_seen !== 1'b0) begin n_bad++; $display("FAIL reset_ready: got %b want 0", ready_seen); end
    n_vec++; if (keypad_out !== 12'h000) begin n_bad++; $display("FAIL reset_kp: got %h want 000", keypad_out); end
    n_vec++; if ({busy, done, err} !== 3'b000) begin n_bad++; $display("FAIL reset_flags: got %b want 000", {busy, done, err}); end
    step(1'b0, 1'b0, 4'd0);
    n_vec++; if (ready_seen !== 1'b1) begin n_bad++; $display("FAIL reset_release_ready: got %b want 1", ready_seen); end
    for (int k = 0; k < 6; k++) begin
      step(1'b0, 1'b0, 4'd0);
      n_vec++; if (keypad_out !== 12'h000 || busy !== 1'b0) begin
        n_bad++; $display("FAIL reset_ignored_code: kp %h busy %b want 000 0", keypad_out, busy); end
    end
  endtask

  task automatic test_single();
    int e;
    step(1'b0, 1'b1, 4'd5);
    n_vec++; if (ready_seen !== 1'b1) begin n_bad++; $display("FAIL single_ready: got %b want 1", ready_seen); end
    e = cyc;
    for (int k = 0; k < 20; k++) begin
      int o;
      logic [11:0] ek;
      logic eb, ed;
      o  = cyc - (e + 2);
      ek = (o == 0 || (o >= 2 && o < 10)) ? 12'h020 : 12'h000;
      eb = (o >= 0 && o < 14);
      ed = (o == 13);
      n_vec++; if (keypad_out !== ek) begin n_bad++; $display("FAIL single_kp o=%0d: got %h want %h", o, keypad_out, ek); end
      n_vec++; if (busy !== eb || done !== ed) begin
        n_bad++; $display("FAIL single_busy_done o=%0d: got %b%b want %b%b", o, busy, done, eb, ed); end
      step(1'b0, 1'b0, 4'd0);
    end
  endtask

  task automatic test_no_bounce();
    int e, busy_cnt, done_cnt;
    busy_cnt = 0; done_cnt = 0;
    step(1'b1, 1'b0, 4'd0);
    step(1'b0, 1'b1, 4'd11);
    e = cyc;
    for (int k = 0; k < 20; k++) begin
      int o;
      logic [11:0] ek;
      o  = cyc - (e + 2);
      ek = (o >= 0 && o < 8) ? 12'h800 : 12'h000;
      n_vec++; if (keypad_out_b !== ek) begin n_bad++; $display("FAIL nobounce_kp o=%0d: got %h want %h", o, keypad_out_b, ek); end
      n_vec++; if (done_b !== (o == 11) || err_b !== 1'b0) begin
        n_bad++; $display("FAIL nobounce_done_err o=%0d: got %b%b want %b0", o, done_b, err_b, (o == 11)); end
      if (busy_b) busy_cnt++;
      if (done_b) done_cnt++;
      step(1'b0, 1'b0, 4'd0);
    end
    n_vec++; if (busy_cnt != 12) begin n_bad++; $display("FAIL nobounce_busy_len: got %0d want 12", busy_cnt); end
    n_vec++; if (done_cnt != 1) begin n_bad++; $display("FAIL nobounce_done_cnt: got %0d want 1", done_cnt); end
    n_vec++; if (code_ready_b !== 1'b1) begin n_bad++; $display("FAIL nobounce_ready: got %b want 1", code_ready_b); end
  endtask

  task automatic test_invalid();
    logic [11:0] ek;
    logic eb, ed, ee, seen1;
    seen1 = 1'b0;
    step(1'b1, 1'b0, 4'd0);
    step(1'b0, 1'b1, 4'd13);
    n_vec++; if (ready_seen !== 1'b1) begin n_bad++; $display("FAIL invalid_ready: got %b want 1", ready_seen); end
    n_vec++; if (err !== 1'b1) begin n_bad++; $display("FAIL invalid_err: got %b want 1", err); end
    n_vec++; if (keypad_out !== 12'h000 || busy !== 1'b0) begin
      n_bad++; $display("FAIL invalid_quiet: kp %h busy %b want 000 0", keypad_out, busy); end
    step(1'b0, 1'b1, 4'd0);
    n_vec++; if (err !== 1'b0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL invalid_err_pulse: err %b busy %b want 0 0", err, busy); end
    for (int k = 0; k < 18; k++) begin
      step(1'b0, 1'b0, 4'd0);
      model_out(cyc, ek, eb, ed, ee);
      if (keypad_out === 12'h001) seen1 = 1'b1;
      n_vec++; if ({keypad_out, busy, done, err} !== {ek, eb, ed, ee}) begin
        n_bad++; $display("FAIL invalid_follow c=%0d: got %h %b%b%b want %h %b%b%b",
                          cyc, keypad_out, busy, done, err, ek, eb, ed, ee); end
    end
    n_vec++; if (seen1 !== 1'b1) begin n_bad++; $display("FAIL invalid_code0_press: got %b want 1", seen1); end
  endtask

  task automatic test_back_to_back();
    int codes[5] = '{1, 2, 3, 4, 7};
    int order[$];
    int done_at[$];
    int idx, guard;
    logic [11:0] ek, last_nz;
    logic eb, ed, ee, saw_stall;
    idx = 0; guard = 0; saw_stall = 1'b0; last_nz = '0;
    step(1'b1, 1'b0, 4'd0);
    while (guard < 110) begin
      if (idx < 5) step(1'b0, 1'b1, 4'(codes[idx]));
      else         step(1'b0, 1'b0, 4'd0);
      if (idx < 5 && ready_seen) idx++;
      if (!ready_seen) saw_stall = 1'b1;
      guard++;
      model_out(cyc, ek, eb, ed, ee);
      n_vec++; if (ready_seen !== exp_ready) begin
        n_bad++; $display("FAIL b2b_ready c=%0d: got %b want %b", cyc, ready_seen, exp_ready); end
      n_vec++; if ({keypad_out, busy, done} !== {ek, eb, ed}) begin
        n_bad++; $display("FAIL b2b_out c=%0d: got %h %b%b want %h %b%b", cyc, keypad_out, busy, done, ek, eb, ed); end
      if (keypad_out != 12'h000) last_nz = keypad_out;
      if (done) begin
        done_at.push_back(cyc);
        for (int b = 0; b < 12; b++) if (last_nz[b]) order.push_back(b);
      end
    end
    n_vec++; if (idx != 5) begin n_bad++; $display("FAIL b2b_transfers: got %0d want 5", idx); end
    n_vec++; if (saw_stall !== 1'b1) begin n_bad++; $display("FAIL b2b_full_stall: got %b want 1", saw_stall); end
    n_vec++; if (done_at.size() != 5) begin n_bad++; $display("FAIL b2b_done_cnt: got %0d want 5", done_at.size()); end
    for (int i = 0; i < 5 && i < order.size(); i++) begin
      n_vec++; if (order[i] != codes[i]) begin n_bad++; $display("FAIL b2b_order[%0d]: got %0d want %0d", i, order[i], codes[i]); end
    end
    for (int i = 1; i < done_at.size(); i++) begin
      n_vec++; if (done_at[i] - done_at[i-1] != P) begin
        n_bad++; $display("FAIL b2b_spacing[%0d]: got %0d want %0d", i, done_at[i] - done_at[i-1], P); end
    end
  endtask

  task automatic test_reset_mid();
    int e1, guard;
    step(1'b1, 1'b0, 4'd0);
    step(1'b0, 1'b1, 4'd6);
    e1 = cyc;
    step(1'b0, 1'b1, 4'd8);
    step(1'b0, 1'b1, 4'd10);
    guard = 0;
    while (cyc < e1 + 6 && guard < 20) begin step(1'b0, 1'b0, 4'd0); guard++; end
    n_vec++; if (keypad_out !== 12'h040) begin n_bad++; $display("FAIL midrst_hold: got %h want 040", keypad_out); end
    step(1'b1, 1'b0, 4'd0);
    n_vec++; if (keypad_out !== 12'h000 || busy !== 1'b0 || done !== 1'b0) begin
      n_bad++; $display("FAIL midrst_clear: kp %h busy %b done %b want 000 0 0", keypad_out, busy, done); end
    step(1'b0, 1'b0, 4'd0);
    n_vec++; if (ready_seen !== 1'b1) begin n_bad++; $display("FAIL midrst_ready: got %b want 1", ready_seen); end
    for (int k = 0; k < 40; k++) begin
      step(1'b0, 1'b0, 4'd0);
      n_vec++; if (keypad_out !== 12'h000 || busy !== 1'b0) begin
        n_bad++; $display("FAIL midrst_no_press c=%0d: kp %h busy %b", cyc, keypad_out, busy); end
    end
  endtask

  task automatic test_random();
    logic [11:0] ek;
    logic eb, ed, ee, v;
    logic [3:0] c;
    int n_done, n_err;
    n_done = 0; n_err = 0;
    step(1'b1, 1'b0, 4'd0);
    for (int k = 0; k < 1000; k++) begin
      if (k < 500)       v = ($urandom_range(0, 2) == 0);
      else if (k < 900)  v = ($urandom_range(0, 19) == 0);
      else               v = 1'b0;
      c = 4'($urandom_range(0, 15));
      step(1'b0, v, c);
      model_out(cyc, ek, eb, ed, ee);
      if (done) n_done++;
      if (err)  n_err++;
      n_vec++; if (ready_seen !== exp_ready) begin
        n_bad++; $display("FAIL rand_ready c=%0d: got %b want %b", cyc, ready_seen, exp_ready); end
      n_vec++; if ({keypad_out, busy, done, err} !== {ek, eb, ed, ee}) begin
        n_bad++; $display("FAIL rand_out c=%0d: got %h %b%b%b want %h %b%b%b",
                          cyc, keypad_out, busy, done, err, ek, eb, ed, ee); end
      n_vec++; if ($countones(keypad_out) > 1) begin
        n_bad++; $display("FAIL rand_onehot c=%0d: got %h want at most one bit", cyc, keypad_out); end
    end
    n_vec++; if (n_done != presses.size()) begin n_bad++; $display("FAIL rand_done_cnt: got %0d want %0d", n_done, presses.size()); end
    n_vec++; if (n_err != err_q.size()) begin n_bad++; $display("FAIL rand_err_cnt: got %0d want %0d", n_err, err_q.size()); end
  endtask

  initial begin
    rst = 1'b1; code_valid = 1'b0; code_in = 4'd0;
    test_reset();
    test_single();
    test_no_bounce();
    test_invalid();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
